// File: rtl/obi_slave_mo.sv
// OBI memory slave with byte-lane writes, out-of-range error responses and an
// in-order response FIFO that allows up to MAX_OUTSTANDING pending transfers.
module obi_slave_mo #(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    DEPTH_WORDS     = 256,
    parameter int                    MAX_OUTSTANDING = 4,
    parameter int                    ID_WIDTH        = 4,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA        = DATA_WIDTH'(32'hDEAD_BEEF)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    obi_req_i,
    output logic                    obi_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   obi_addr_i,
    input  logic                    obi_we_i,
    input  logic [DATA_WIDTH/8-1:0] obi_be_i,
    input  logic [DATA_WIDTH-1:0]   obi_wdata_i,
    input  logic [ID_WIDTH-1:0]     obi_aid_i,
    output logic                    obi_rvalid_o,
    input  logic                    obi_rready_i,
    output logic [DATA_WIDTH-1:0]   obi_rdata_o,
    output logic                    obi_err_o,
    output logic [ID_WIDTH-1:0]     obi_rid_o
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFFS  = $clog2(BYTES);
    localparam int IW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int PW    = $clog2(MAX_OUTSTANDING);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic                  err;
        logic [ID_WIDTH-1:0]   id;
    } rsp_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
    rsp_t                  fifo [MAX_OUTSTANDING];

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW:0]           count;

    logic                  accept;
    logic                  pop;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [IW-1:0]         mem_idx;
    logic [DATA_WIDTH-1:0] be_mask;
    rsp_t                  push_rsp;
    rsp_t                  head;

    // Grant depends only on registered occupancy, never on rready.
    assign obi_gnt_o    = !reset_i && (count < (PW+1)'(MAX_OUTSTANDING));
    assign obi_rvalid_o = (count != '0);
    assign accept       = obi_req_i && obi_gnt_o;
    assign pop          = obi_rvalid_o && obi_rready_i;

    assign word_idx = obi_addr_i >> OFFS;
    assign in_range = word_idx < ADDR_WIDTH'(DEPTH_WORDS);
    assign mem_idx  = word_idx[IW-1:0];

    always_comb begin
        be_mask = '0;
        for (int b = 0; b < BYTES; b++) begin
            be_mask[8*b +: 8] = {8{obi_be_i[b]}};
        end
    end

    always_comb begin
        push_rsp.id  = obi_aid_i;
        push_rsp.err = !in_range;
        if (!in_range) begin
            push_rsp.rdata = obi_we_i ? '0 : ERR_DATA;
        end else if (obi_we_i) begin
            push_rsp.rdata = '0;
        end else begin
            push_rsp.rdata = mem[mem_idx] & be_mask;
        end
    end

    // NOTE: memory and FIFO payload storage carry no reset; only the control
    // state (pointers, count) is cleared, so the data arrays map onto RAM.
    always_ff @(posedge clk_i) begin
        if (accept && obi_we_i && in_range) begin
            for (int b = 0; b < BYTES; b++) begin
                if (obi_be_i[b]) begin
                    mem[mem_idx][8*b +: 8] <= obi_wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            fifo[wr_ptr] <= push_rsp;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({accept, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Gating with rvalid keeps the uninitialised payload from ever showing.
    assign head        = fifo[rd_ptr];
    assign obi_rdata_o = obi_rvalid_o ? head.rdata : '0;
    assign obi_err_o   = obi_rvalid_o ? head.err   : 1'b0;
    assign obi_rid_o   = obi_rvalid_o ? head.id    : '0;

endmodule

// File: tb/tb_obi_slave_mo.sv
// Directed bench for obi_slave_mo: writes, byte lanes, errors, backpressure
// with a full response FIFO, and reset with responses outstanding.
module tb_obi_slave_mo;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        obi_req_i;
    logic        obi_gnt_o;
    logic [31:0] obi_addr_i;
    logic        obi_we_i;
    logic [3:0]  obi_be_i;
    logic [31:0] obi_wdata_i;
    logic [3:0]  obi_aid_i;
    logic        obi_rvalid_o;
    logic        obi_rready_i;
    logic [31:0] obi_rdata_o;
    logic        obi_err_o;
    logic [3:0]  obi_rid_o;

    int checks = 0;
    int errors = 0;

    obi_slave_mo #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(256),
        .MAX_OUTSTANDING(4), .ID_WIDTH(4), .ERR_DATA(32'hDEAD_BEEF)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .obi_req_i(obi_req_i), .obi_gnt_o(obi_gnt_o),
        .obi_addr_i(obi_addr_i), .obi_we_i(obi_we_i), .obi_be_i(obi_be_i),
        .obi_wdata_i(obi_wdata_i), .obi_aid_i(obi_aid_i),
        .obi_rvalid_o(obi_rvalid_o), .obi_rready_i(obi_rready_i),
        .obi_rdata_o(obi_rdata_o), .obi_err_o(obi_err_o), .obi_rid_o(obi_rid_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present a request and hold it until it is accepted (bounded).
    task automatic send(input string tag, input logic [31:0] addr, input logic we,
                        input logic [3:0] be, input logic [31:0] wdata, input logic [3:0] aid);
        bit granted = 1'b0;
        obi_req_i   = 1'b1;
        obi_addr_i  = addr;
        obi_we_i    = we;
        obi_be_i    = be;
        obi_wdata_i = wdata;
        obi_aid_i   = aid;
        for (int i = 0; i < 20 && !granted; i++) begin
            if (obi_gnt_o) granted = 1'b1;
            tick();
        end
        obi_req_i = 1'b0;
        check({tag, "_gnt"}, 64'(granted), 64'd1);
    endtask

    // Wait for a response (bounded), compare the head, then pop it.
    task automatic expect_rsp(input string tag, input logic [31:0] rdata,
                              input logic err, input logic [3:0] rid);
        for (int i = 0; i < 20 && !obi_rvalid_o; i++) tick();
        check({tag, "_rvalid"}, 64'(obi_rvalid_o), 64'd1);
        check({tag, "_rdata"}, 64'(obi_rdata_o), 64'(rdata));
        check({tag, "_err"}, 64'(obi_err_o), 64'(err));
        check({tag, "_rid"}, 64'(obi_rid_o), 64'(rid));
        obi_rready_i = 1'b1;
        tick();
        obi_rready_i = 1'b0;
    endtask

    initial begin
        reset_i      = 1'b1;
        obi_req_i    = 1'b0;
        obi_addr_i   = '0;
        obi_we_i     = 1'b0;
        obi_be_i     = '0;
        obi_wdata_i  = '0;
        obi_aid_i    = '0;
        obi_rready_i = 1'b0;
        repeat (3) tick();
        check("rst_gnt", 64'(obi_gnt_o), 64'd0);
        check("rst_rvalid", 64'(obi_rvalid_o), 64'd0);
        reset_i = 1'b0;
        #1;
        check("post_rst_gnt", 64'(obi_gnt_o), 64'd1);
        check("post_rst_rdata", 64'(obi_rdata_o), 64'd0);
        check("post_rst_err", 64'(obi_err_o), 64'd0);
        check("post_rst_rid", 64'(obi_rid_o), 64'd0);

        // Full-word write then read, with one-cycle latency check
        send("w08", 32'h08, 1'b1, 4'hF, 32'h1337C0DE, 4'd3);
        check("latency_rvalid", 64'(obi_rvalid_o), 64'd1);
        expect_rsp("w08_rsp", 32'h0, 1'b0, 4'd3);
        send("r08", 32'h08, 1'b0, 4'hF, 32'h0, 4'd4);
        expect_rsp("r08_rsp", 32'h1337C0DE, 1'b0, 4'd4);

        // Byte-lane write and partial read
        send("w0c", 32'h0C, 1'b1, 4'hF, 32'h33333333, 4'd1);
        expect_rsp("w0c_rsp", 32'h0, 1'b0, 4'd1);
        send("w0f", 32'h0F, 1'b1, 4'h8, 32'h1337C0DE, 4'd2);
        expect_rsp("w0f_rsp", 32'h0, 1'b0, 4'd2);
        send("r0c", 32'h0C, 1'b0, 4'hF, 32'h0, 4'd1);
        expect_rsp("r0c_rsp", 32'h13333333, 1'b0, 4'd1);
        send("r0a", 32'h0A, 1'b0, 4'hC, 32'h0, 4'd2);
        expect_rsp("r0a_rsp", 32'h13370000, 1'b0, 4'd2);

        // Out-of-range read/write; word 0 would alias on a truncated index
        send("w00", 32'h00, 1'b1, 4'hF, 32'hA5A5A5A5, 4'd0);
        expect_rsp("w00_rsp", 32'h0, 1'b0, 4'd0);
        send("r400", 32'h400, 1'b0, 4'hF, 32'h0, 4'd5);
        expect_rsp("r400_rsp", 32'hDEADBEEF, 1'b1, 4'd5);
        send("w400", 32'h400, 1'b1, 4'hF, 32'hFFFFFFFF, 4'd6);
        expect_rsp("w400_rsp", 32'h0, 1'b1, 4'd6);
        send("r00", 32'h00, 1'b0, 4'hF, 32'h0, 4'd7);
        expect_rsp("r00_rsp", 32'hA5A5A5A5, 1'b0, 4'd7);

        // be=0 read and write are harmless
        send("r08_be0", 32'h08, 1'b0, 4'h0, 32'h0, 4'd8);
        expect_rsp("r08_be0_rsp", 32'h0, 1'b0, 4'd8);
        send("w08_be0", 32'h08, 1'b1, 4'h0, 32'hFFFFFFFF, 4'd9);
        expect_rsp("w08_be0_rsp", 32'h0, 1'b0, 4'd9);
        send("r08_again", 32'h08, 1'b0, 4'hF, 32'h0, 4'd10);
        expect_rsp("r08_again_rsp", 32'h1337C0DE, 1'b0, 4'd10);

        // Back-to-back write then read of the same word
        send("w1c", 32'h1C, 1'b1, 4'hF, 32'hCAFEF00D, 4'd6);
        send("r1c", 32'h1C, 1'b0, 4'hF, 32'h0, 4'd7);
        expect_rsp("w1c_rsp", 32'h0, 1'b0, 4'd6);
        expect_rsp("r1c_rsp", 32'hCAFEF00D, 1'b0, 4'd7);

        // Fill FIFO with rready low, fifth request must wait for a pop
        send("f0", 32'h00, 1'b0, 4'hF, 32'h0, 4'd8);
        send("f1", 32'h08, 1'b0, 4'hF, 32'h0, 4'd9);
        send("f2", 32'h0C, 1'b0, 4'hF, 32'h0, 4'd10);
        send("f3", 32'h1C, 1'b0, 4'hF, 32'h0, 4'd11);
        obi_req_i  = 1'b1;
        obi_addr_i = 32'h08;
        obi_we_i   = 1'b0;
        obi_be_i   = 4'hF;
        obi_aid_i  = 4'd12;
        check("full_gnt", 64'(obi_gnt_o), 64'd0);
        check("full_head_rid", 64'(obi_rid_o), 64'd8);
        tick();
        check("full_gnt_hold", 64'(obi_gnt_o), 64'd0);
        check("full_head_rid_hold", 64'(obi_rid_o), 64'd8);
        check("full_head_rdata_hold", 64'(obi_rdata_o), 64'hA5A5A5A5);
        obi_rready_i = 1'b1;
        tick();
        check("after_pop_gnt", 64'(obi_gnt_o), 64'd1);
        check("after_pop_rid", 64'(obi_rid_o), 64'd9);
        check("after_pop_rdata", 64'(obi_rdata_o), 64'h1337C0DE);
        tick();
        obi_req_i    = 1'b0;
        obi_rready_i = 1'b0;
        check("push_pop_gnt", 64'(obi_gnt_o), 64'd1);
        expect_rsp("f2_rsp", 32'h13333333, 1'b0, 4'd10);
        expect_rsp("f3_rsp", 32'hCAFEF00D, 1'b0, 4'd11);
        expect_rsp("f4_rsp", 32'h1337C0DE, 1'b0, 4'd12);
        check("drained_rvalid", 64'(obi_rvalid_o), 64'd0);

        // Reset with three responses outstanding and a request presented
        send("w28", 32'h28, 1'b1, 4'hF, 32'h0A0A0A0A, 4'd1);
        send("w2c", 32'h2C, 1'b1, 4'hF, 32'h0B0B0B0B, 4'd2);
        send("w30", 32'h30, 1'b1, 4'hF, 32'h0C0C0C0C, 4'd3);
        reset_i     = 1'b1;
        obi_req_i   = 1'b1;
        obi_addr_i  = 32'h28;
        obi_we_i    = 1'b1;
        obi_be_i    = 4'hF;
        obi_wdata_i = 32'hBADBAD00;
        obi_aid_i   = 4'd15;
        #1;
        check("in_rst_gnt", 64'(obi_gnt_o), 64'd0);
        tick();
        check("in_rst_rvalid", 64'(obi_rvalid_o), 64'd0);
        tick();
        reset_i   = 1'b0;
        obi_req_i = 1'b0;
        #1;
        check("rel_rdata", 64'(obi_rdata_o), 64'd0);
        check("rel_err", 64'(obi_err_o), 64'd0);
        check("rel_rid", 64'(obi_rid_o), 64'd0);
        repeat (2) tick();
        check("rel_no_stale", 64'(obi_rvalid_o), 64'd0);
        send("r28", 32'h28, 1'b0, 4'hF, 32'h0, 4'd4);
        expect_rsp("r28_rsp", 32'h0A0A0A0A, 1'b0, 4'd4);
        send("r2c", 32'h2C, 1'b0, 4'hF, 32'h0, 4'd5);
        expect_rsp("r2c_rsp", 32'h0B0B0B0B, 1'b0, 4'd5);
        send("r30", 32'h30, 1'b0, 4'hF, 32'h0, 4'd6);
        expect_rsp("r30_rsp", 32'h0C0C0C0C, 1'b0, 4'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
